pc_redirect: RTL and testbench
==============================

# pc_redirect

Fetch-side consumer of the branch-condition result. Holds the program counter, applies resolved branch/jump redirects from the execute stage, and sequences a one-cycle pipeline flush after every redirect. It also freezes fetch on HALT and counts taken redirects for performance debug. Sits between the execute stage's branch-condition/target logic and the instruction-memory address port.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard stall from decode; holds the PC when no redirect is present
- br_valid  in  1  execute stage holds a resolved branch or jump this cycle
- br_taken  in  1  branch condition result (1 = taken); meaningful only with br_valid
- jmp  in  1  unconditional jump in execute; with br_valid, treated as taken regardless of br_taken
- br_target  in  16  redirect address from execute
- halt  in  1  HALT decoded this cycle
- pc  out  16  current fetch address
- pc_inc  out  16  pc + 2, modulo 2^16, combinational from pc
- flush  out  1  registered; kill the IF/ID and ID/EX pipeline registers at the next edge
- halted  out  1  high while in HALT
- redirect_cnt  out  16  number of accepted redirects, saturating

## Operation
- States: RUN, FLUSH, HALT. Reset state is RUN.
- redirect = br_valid & (br_taken | jmp). It is evaluated only in RUN.
- RUN transitions:
  - If redirect: pc <= {br_target[15:1], 1'b0}; state <= FLUSH; redirect_cnt increments.
  - Else if halt & ~stall: state <= HALT; pc holds.
  - Else if stall: pc holds.
  - Else: pc <= pc_inc.
- Priority is redirect > halt > stall > increment. The redirecting instruction is older than anything in decode, so a redirect overrides both stall and halt in the same cycle.
- FLUSH lasts exactly one cycle:
  - flush = 1.
  - br_valid, halt and stall are ignored, because they belong to the squashed wrong-path instructions.
  - pc <= pc_inc, since the target was fetched this cycle.
  - state <= RUN.
- HALT:
  - pc frozen; halted = 1; flush = 0.
  - All inputs ignored; only rst exits.
- redirect_cnt saturates at 16'hFFFF and never wraps.
- pc_inc wraps: 16'hFFFE -> 16'h0000. A redirect target with bit 0 set is forced even.

## Timing
- Reset: pc = RESET_PC, state = RUN, flush = 0, halted = 0, redirect_cnt = 0. rst overrides every other input in the same edge, including mid-FLUSH and in HALT.
- Redirect latency is one cycle:
  - Redirect sampled at edge E.
  - From E, pc = target and flush = 1 for exactly one cycle.
  - At edge E+1, flush = 0 and pc = target + 2, unless a stall occurs in RUN afterwards.
- flush and halted are registered state decodes. pc_inc is combinational from pc.
- Back-to-back redirects: a redirect presented in the FLUSH cycle is dropped. The next redirect can be accepted in the first RUN cycle after FLUSH.
- halt and redirect in the same cycle: the redirect wins and halt is discarded.

## Test plan
- Reset/increment: rst for 1 cycle, then 4 idle cycles -> pc = 0000, 0002, 0004, 0006, 0008; flush = 0; halted = 0.
- Taken branch:
  - Stimulus: at pc = 0x0010, pulse br_valid = 1, br_taken = 1, br_target = 0x0101.
  - Response: next cycle pc = 0x0100 and flush = 1; the cycle after, pc = 0x0102 and flush = 0; redirect_cnt = 1.
- Not-taken plus jump:
  - br_valid = 1, br_taken = 0, jmp = 0 -> pc increments normally and redirect_cnt is unchanged.
  - br_valid = 1, br_taken = 0, jmp = 1, target 0x0200 -> pc = 0x0200.
- Stall/redirect priority:
  - stall held for 3 cycles -> pc constant.
  - Redirect to 0x0040 during stall -> pc = 0x0040 next cycle.
  - Second redirect to 0x0080 in the FLUSH cycle -> ignored; pc = 0x0042.
- Halt:
  - halt with stall = 1 -> ignored.
  - halt with stall = 0 at pc = 0x0030 -> halted = 1, pc stays 0x0030 despite redirects.
  - rst -> pc = 0, halted = 0.
- Wrap/saturation:
  - Redirect to 0xFFFE, then one idle cycle -> pc = 0x0000.
  - Preload 0xFFFF accepted redirects -> redirect_cnt stays 0xFFFF on further redirects.

Source files
------------

// File: rtl/pc_redirect.sv
// pc_redirect: fetch program counter with branch/jump redirect, one-cycle
// post-redirect flush, HALT freeze and a saturating taken-redirect counter.
module pc_redirect #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    // Saturation ceiling of redirect_cnt; lowered only to exercise saturation quickly
    parameter logic [15:0] CNT_MAX  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        jmp,
    input  logic [15:0] br_target,
    input  logic        halt,
    output logic [15:0] pc,
    output logic [15:0] pc_inc,
    output logic        flush,
    output logic        halted,
    output logic [15:0] redirect_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc_q, pc_nxt;
    logic [15:0] cnt_q, cnt_nxt;
    logic        redirect;

    // A jump is taken regardless of the condition result
    assign redirect = br_valid & (br_taken | jmp);
    assign pc_inc   = pc_q + 16'd2;

    // Next-state: redirect > halt > stall > increment in RUN; FLUSH always
    // advances past the target and drops wrong-path requests; HALT freezes.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        cnt_nxt   = cnt_q;
        case (state)
            RUN: begin
                if (redirect) begin
                    pc_nxt    = {br_target[15:1], 1'b0};
                    state_nxt = FLUSH;
                    if (cnt_q != CNT_MAX)
                        cnt_nxt = cnt_q + 16'd1;
                end else if (halt && !stall) begin
                    state_nxt = HALT;
                end else if (!stall) begin
                    pc_nxt = pc_inc;
                end
            end
            FLUSH: begin
                pc_nxt    = pc_inc;
                state_nxt = RUN;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State, PC and counter registers; synchronous reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc_q  <= RESET_PC;
            cnt_q <= 16'd0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    assign pc           = pc_q;
    assign flush        = (state == FLUSH);
    assign halted       = (state == HALT);
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect.sv
// Directed self-checking bench for pc_redirect.
module tb_pc_redirect;

    logic        clk = 1'b0;
    logic        rst, stall, br_valid, br_taken, jmp, halt;
    logic [15:0] br_target;
    logic [15:0] pc, pc_inc, redirect_cnt;
    logic        flush, halted;
    logic [15:0] s_pc, s_pc_inc, s_cnt;
    logic        s_flush, s_halted;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pc_redirect dut (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid),
        .br_taken(br_taken), .jmp(jmp), .br_target(br_target), .halt(halt),
        .pc(pc), .pc_inc(pc_inc), .flush(flush), .halted(halted),
        .redirect_cnt(redirect_cnt)
    );

    // Same stimulus, low saturation ceiling
    pc_redirect #(.CNT_MAX(16'h0003)) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid),
        .br_taken(br_taken), .jmp(jmp), .br_target(br_target), .halt(halt),
        .pc(s_pc), .pc_inc(s_pc_inc), .flush(s_flush), .halted(s_halted),
        .redirect_cnt(s_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one edge; outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; br_valid = 0; br_taken = 0; jmp = 0; halt = 0; br_target = 16'h0;
    endtask

    task automatic set_br(input logic [15:0] tgt);
        br_valid = 1; br_taken = 1; br_target = tgt;
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        rst = 0;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_flush", {15'd0, flush}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_cnt", redirect_cnt, 16'd0);
        chk("rst_pc_inc", pc_inc, 16'h0002);

        for (int i = 1; i <= 4; i++) begin
            step();
            chk("inc_pc", pc, 16'(2 * i));
            chk("inc_flush", {15'd0, flush}, 16'd0);
        end
        for (int i = 0; i < 4; i++) step();
        chk("pc_at_10", pc, 16'h0010);

        // taken branch to odd target
        set_br(16'h0101);
        step(); idle();
        chk("br_pc", pc, 16'h0100);
        chk("br_flush", {15'd0, flush}, 16'd1);
        chk("br_cnt", redirect_cnt, 16'd1);
        step();
        chk("br_pc2", pc, 16'h0102);
        chk("br_flush2", {15'd0, flush}, 16'd0);

        // not taken
        br_valid = 1; br_target = 16'h0300;
        step(); idle();
        chk("nt_pc", pc, 16'h0104);
        chk("nt_cnt", redirect_cnt, 16'd1);

        // jump without taken
        br_valid = 1; jmp = 1; br_target = 16'h0200;
        step(); idle();
        chk("jmp_pc", pc, 16'h0200);
        chk("jmp_cnt", redirect_cnt, 16'd2);
        step();
        chk("jmp_pc2", pc, 16'h0202);

        // stall holds pc
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc, 16'h0202);
        end
        // redirect beats stall
        set_br(16'h0040);
        step();
        chk("stbr_pc", pc, 16'h0040);
        chk("stbr_flush", {15'd0, flush}, 16'd1);
        // second redirect, stall and halt in FLUSH are all ignored
        set_br(16'h0080); halt = 1;
        step(); idle();
        chk("fl_drop_pc", pc, 16'h0042);
        chk("fl_drop_cnt", redirect_cnt, 16'd3);
        chk("fl_drop_halted", {15'd0, halted}, 16'd0);

        // get to 0x0030
        set_br(16'h002E);
        step(); idle();
        step();
        chk("pc_at_30", pc, 16'h0030);
        halt = 1; stall = 1;
        step();
        chk("halt_st_pc", pc, 16'h0030);
        chk("halt_st_halted", {15'd0, halted}, 16'd0);
        stall = 0;
        step(); idle();
        chk("halt_pc", pc, 16'h0030);
        chk("halt_halted", {15'd0, halted}, 16'd1);
        set_br(16'h0500);
        step(); step(); idle();
        chk("halt_br_pc", pc, 16'h0030);
        chk("halt_br_halted", {15'd0, halted}, 16'd1);
        chk("halt_br_flush", {15'd0, flush}, 16'd0);
        chk("halt_br_cnt", redirect_cnt, 16'd4);
        rst = 1;
        step();
        rst = 0;
        chk("halt_rst_pc", pc, 16'h0000);
        chk("halt_rst_halted", {15'd0, halted}, 16'd0);
        chk("halt_rst_cnt", redirect_cnt, 16'd0);

        // halt and redirect together: redirect wins
        set_br(16'h0600); halt = 1;
        step(); idle();
        chk("hbr_pc", pc, 16'h0600);
        chk("hbr_flush", {15'd0, flush}, 16'd1);
        step();
        chk("hbr_pc2", pc, 16'h0602);
        chk("hbr_halted", {15'd0, halted}, 16'd0);

        // reset mid-FLUSH
        set_br(16'h0700);
        step(); idle();
        chk("rfl_flush", {15'd0, flush}, 16'd1);
        rst = 1;
        step();
        rst = 0;
        chk("rfl_pc", pc, 16'h0000);
        chk("rfl_flush2", {15'd0, flush}, 16'd0);
        chk("rfl_cnt", redirect_cnt, 16'd0);

        // wrap
        set_br(16'hFFFE);
        step(); idle();
        chk("wrap_pc", pc, 16'hFFFE);
        chk("wrap_pc_inc", pc_inc, 16'h0000);
        step();
        chk("wrap_pc2", pc, 16'h0000);

        // saturation: 5 more redirects
        for (int i = 0; i < 5; i++) begin
            set_br(16'h1000);
            step(); idle();
            step();
        end
        chk("sat_main_cnt", redirect_cnt, 16'd6);
        chk("sat_cnt", s_cnt, 16'h0003);
        chk("sat_pc", s_pc, 16'h1002);
        chk("sat_pc_inc", s_pc_inc, 16'h1004);
        chk("sat_flags", {14'd0, s_flush, s_halted}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
